digit_frame_builder: RTL and testbench

DIGIT_FRAME_BUILDER -- requirements
Module: digit_frame_builder

---
 rtl/digit_frame_builder.sv | 127 ++++++++++++
 tb/tb_digit_frame_builder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_builder.sv
// Double-buffered 8-digit seven-segment frame builder: shadow writes, frame-aligned swap,
// hex decode, leading-zero blanking and per-frame PWM digit enables.
module digit_frame_builder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic        wr_raw,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  output logic        commit_pending,
  input  logic [3:0]  brightness,
  input  logic        blank_lz,
  output logic [71:0] display_bits
);

  // Entry layout: [8] = raw mode, [7:0] = data byte.
  logic [8:0]  shadow_q [8];
  logic [8:0]  shadow_d [8];
  logic [8:0]  active_q [8];
  logic [8:0]  active_d [8];
  logic        pending_q, pending_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic [71:0] display_q, display_d;
  logic        wr_fire;
  logic        swap;
  logic [7:0]  blank;

  function automatic logic [7:0] decode(input logic [8:0] entry);
    logic [6:0] seg;
    if (entry[8]) begin
      return entry[7:0];
    end
    unique case (entry[3:0])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return {entry[4], seg};
  endfunction

  assign wr_ready       = ~pending_q;
  assign commit_pending = pending_q;
  assign display_bits   = display_q;
  assign wr_fire        = wr_valid & wr_ready;
  // Writes are blocked while pending, so the swap always sees the final shadow contents.
  assign swap           = frame_tick & pending_q;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire) begin
      shadow_d[wr_addr] = {wr_raw, wr_data};
    end
  end

  always_comb begin
    active_d = swap ? shadow_q : active_q;
  end

  always_comb begin
    pending_d = pending_q;
    if (swap) begin
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  assign pwm_cnt_d = frame_tick ? pwm_cnt_q + 4'd1 : pwm_cnt_q;

  // Blank from digit 7 downward while entries are hex zero with no dp; digit 0 never blanks.
  always_comb begin
    logic run;
    blank = 8'h00;
    run   = blank_lz;
    for (int i = 7; i >= 1; i--) begin
      run      = run & ~active_d[i][8] & (active_d[i][4:0] == 5'd0);
      blank[i] = run;
    end
  end

  always_comb begin
    logic pwm_on;
    display_d = '0;
    pwm_on    = pwm_cnt_q < brightness;
    for (int i = 0; i < 8; i++) begin
      display_d[8*i +: 8] = blank[i] ? 8'h00 : decode(active_d[i]);
      display_d[64 + i]   = ~blank[i] & pwm_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
      pwm_cnt_q <= 4'd0;
      display_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pwm_cnt_q <= pwm_cnt_d;
      if (frame_tick) begin
        display_q <= display_d;
      end
    end
  end

endmodule

// File: tb/tb_digit_frame_builder.sv
// Self-checking bench for digit_frame_builder: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_digit_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic        wr_raw;
  logic [7:0]  wr_data;
  logic        commit;
  logic        commit_pending;
  logic [3:0]  brightness;
  logic        blank_lz;
  logic [71:0] display_bits;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  m_shadow [8];
  logic [8:0]  m_active [8];
  logic        m_pend;
  logic [3:0]  m_pwm;
  logic [71:0] m_disp;
  logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  digit_frame_builder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_raw         (wr_raw),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .brightness     (brightness),
    .blank_lz       (blank_lz),
    .display_bits   (display_bits)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] model_frame(input logic [3:0] pwm, input logic [3:0] br,
                                              input logic blz);
    logic [71:0] r;
    int keep_top;
    r = '0;
    keep_top = 7;
    if (blz) begin
      while (keep_top > 0 && m_active[keep_top][8] == 1'b0 && m_active[keep_top][4:0] == 5'd0)
        keep_top--;
    end
    for (int i = 0; i < 8; i++) begin
      if (!(blz && i > keep_top)) begin
        if (m_active[i][8]) r[8*i +: 8] = m_active[i][7:0];
        else r[8*i +: 8] = seg_tab[m_active[i][3:0]] | {m_active[i][4], 7'd0};
        r[64 + i] = (pwm < br);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pend = 1'b0;
    m_pwm  = 4'd0;
    m_disp = '0;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge, then idle inputs.
  task automatic step(input logic wv, input logic [2:0] wa, input logic wraw,
                      input logic [7:0] wd, input logic cm, input logic ft);
    wr_valid = wv; wr_addr = wa; wr_raw = wraw; wr_data = wd; commit = cm; frame_tick = ft;
    if (wv && !m_pend) m_shadow[wa] = {wraw, wd};
    if (ft && m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end else if (cm) begin
      m_pend = 1'b1;
    end
    if (ft) begin
      m_disp = model_frame(m_pwm, brightness, blank_lz);
      m_pwm  = m_pwm + 4'd1;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0; commit = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (display_bits !== 72'd0) begin
      n_err++; $display("FAIL reset_display got %h want 0", display_bits);
    end
    n_vec++;
    if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_flags got pend=%b rdy=%b want 0/1", commit_pending, wr_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    brightness = 4'd15; blank_lz = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0, 8'(i + 1), 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits[31:0] !== 32'h664F5B06) begin
      n_err++; $display("FAIL basic_segs got %h want 664f5b06", display_bits[31:0]);
    end
    n_vec++;
    if (display_bits[71:64] !== 8'hFF || commit_pending !== 1'b0) begin
      n_err++; $display("FAIL basic_en got en=%h pend=%b want ff/0",
                        display_bits[71:64], commit_pending);
    end
    n_vec++;
    if (display_bits !== m_disp) begin
      n_err++; $display("FAIL basic_model got %h want %h", display_bits, m_disp);
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 3'd5, 1'b0, 8'h09, 1'b1, 1'b0);
    n_vec++;
    if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_pending got pend=%b rdy=%b want 1/0", commit_pending, wr_ready);
    end
    step(1'b1, 3'd0, 1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits[47:40] !== 8'h6F || display_bits[7:0] !== 8'h06) begin
      n_err++; $display("FAIL bp_contents got d5=%h d0=%h want 6f/06",
                        display_bits[47:40], display_bits[7:0]);
    end
    n_vec++;
    if (wr_ready !== 1'b1 || display_bits !== m_disp) begin
      n_err++; $display("FAIL bp_after got rdy=%b disp=%h want 1/%h", wr_ready, display_bits, m_disp);
    end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, (i == 2) ? 8'h07 : 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    blank_lz = 1'b1; brightness = 4'd15;
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits[71:64] !== 8'h07) begin
      n_err++; $display("FAIL blank_en got %h want 07", display_bits[71:64]);
    end
    n_vec++;
    if (display_bits[63:0] !== 64'h0000_0000_0007_3F3F) begin
      n_err++; $display("FAIL blank_segs got %h want 00000000_00073f3f", display_bits[63:0]);
    end
    n_vec++;
    if (display_bits !== m_disp) begin
      n_err++; $display("FAIL blank_model got %h want %h", display_bits, m_disp);
    end
  endtask

  task automatic test_pwm();
    do_reset();
    blank_lz = 1'b0; brightness = 4'd4;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      n_vec++;
      if ((display_bits[71:64] != 8'h00) !== (k < 4) || display_bits !== m_disp) begin
        n_err++; $display("FAIL pwm4_frame%0d got %h want %h", k, display_bits, m_disp);
      end
    end
    brightness = 4'd0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      n_vec++;
      if (display_bits[71:64] !== 8'h00) begin
        n_err++; $display("FAIL pwm0_frame%0d got en=%h want 00", k, display_bits[71:64]);
      end
    end
  endtask

  task automatic test_coincide();
    brightness = 4'd15; blank_lz = 1'b0;
    step(1'b1, 3'd0, 1'b0, 8'h0A, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b1);
    n_vec++;
    if (display_bits[7:0] !== 8'h3F || commit_pending !== 1'b1) begin
      n_err++; $display("FAIL coincide_first got d0=%h pend=%b want 3f/1",
                        display_bits[7:0], commit_pending);
    end
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits[7:0] !== 8'h77 || commit_pending !== 1'b0 || display_bits !== m_disp) begin
      n_err++; $display("FAIL coincide_second got %h pend=%b want %h/0",
                        display_bits, commit_pending, m_disp);
    end
  endtask

  task automatic test_raw_blank();
    for (int i = 0; i < 7; i++) step(1'b1, 3'(i), 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0);
    blank_lz = 1'b1; brightness = 4'd15;
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits[63:56] !== 8'h80 || display_bits[55:48] !== 8'h3F) begin
      n_err++; $display("FAIL rawblank_segs got d7=%h d6=%h want 80/3f",
                        display_bits[63:56], display_bits[55:48]);
    end
    n_vec++;
    if (display_bits !== m_disp) begin
      n_err++; $display("FAIL rawblank_model got %h want %h", display_bits, m_disp);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 3'd3, 1'b0, 8'h05, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (commit_pending !== 1'b0 || display_bits !== 72'd0 || wr_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_async got pend=%b rdy=%b disp=%h want 0/1/0",
                        commit_pending, wr_ready, display_bits);
    end
    rst_n = 1'b1;
    brightness = 4'd15; blank_lz = 1'b0;
    step(1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    n_vec++;
    if (display_bits !== {8'hFF, {8{8'h3F}}}) begin
      n_err++; $display("FAIL midreset_frame got %h want ff3f3f3f3f3f3f3f3f", display_bits);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      brightness = 4'($urandom);
      blank_lz   = 1'($urandom);
      step(1'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0), d,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      n_vec++;
      if (display_bits !== m_disp || commit_pending !== m_pend || wr_ready !== !m_pend) begin
        n_err++; $display("FAIL random_%0d got %h pend=%b rdy=%b want %h pend=%b",
                          k, display_bits, commit_pending, wr_ready, m_disp, m_pend);
      end
    end
  endtask

  initial begin
    frame_tick = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_raw = 1'b0; wr_data = 8'd0;
    commit = 1'b0; brightness = 4'd0; blank_lz = 1'b0; rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_blank();
    test_pwm();
    test_coincide();
    test_raw_blank();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
